// File: rtl/ps2_host_init_if.sv
// ============================================================================
// ps2_host_init_if
// PS/2 pin-control and receiver-handshake bundle for ps2_host_init.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ps2_host_init_if;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_enable;
  logic       ready;
  logic       error;

  modport master (
    input  ps2_clk_in, ps2_data_in, rx_byte, rx_valid,
    output ps2_clk_oe, ps2_data_oe, rx_enable, ready, error
  );

  modport slave (
    output ps2_clk_in, ps2_data_in, rx_byte, rx_valid,
    input  ps2_clk_oe, ps2_data_oe, rx_enable, ready, error
  );
endinterface

`default_nettype wire

// File: rtl/ps2_host_init.sv
// ============================================================================
// ps2_host_init
// PS/2 keyboard power-up sequencer: sends 0xFF (optionally 0xF3 + TYPEMATIC
// when PS2_TYPEMATIC_EN is defined), checks responses, then hands off the bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_host_init #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TX_TIMEOUT     = 750000,
  parameter int unsigned RESP_TIMEOUT   = 50000000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter logic [7:0]  TYPEMATIC      = 8'h20
) (
  input  logic            clk,
  input  logic            reset_n,
  ps2_host_init_if.master bus
);

  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_RESP, S_READY, S_FAIL
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_tmr, w_tmr_nxt;
  logic [3:0]      r_bit_cnt, w_bit_cnt_nxt;
  logic [RW-1:0]   r_retry, w_retry_nxt;
  logic [1:0]      r_cmd, w_cmd_nxt;
  logic            r_got_fa, w_got_fa_nxt;
  logic            r_ack_got, w_ack_got_nxt;
  logic            r_clk_oe, w_clk_oe_nxt;
  logic            r_data_oe, w_data_oe_nxt;
  logic            r_clk_s1, r_clk_s2, r_clk_prev;
  logic            r_dat_s1, r_dat_s2;
  logic            w_fall;
  logic            w_retry_req;
  logic [7:0]      w_tx_byte;
  logic            w_bit;

  // Synchronizers idle high so no false edge is seen out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= bus.ps2_clk_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= bus.ps2_data_in;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_s2;

  always_comb begin
    w_tx_byte = (r_cmd == 2'd0) ? 8'hFF : (r_cmd == 2'd1) ? 8'hF3 : TYPEMATIC;
    if (r_bit_cnt < 4'd8)
      w_bit = w_tx_byte[r_bit_cnt[2:0]];
    else if (r_bit_cnt == 4'd8)
      w_bit = ~^w_tx_byte;
    else
      w_bit = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_INHIBIT;
      r_tmr     <= '0;
      r_bit_cnt <= '0;
      r_retry   <= '0;
      r_cmd     <= '0;
      r_got_fa  <= 1'b0;
      r_ack_got <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_retry   <= w_retry_nxt;
      r_cmd     <= w_cmd_nxt;
      r_got_fa  <= w_got_fa_nxt;
      r_ack_got <= w_ack_got_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_data_oe <= w_data_oe_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tmr_nxt     = r_tmr + 32'd1;
    w_bit_cnt_nxt = r_bit_cnt;
    w_retry_nxt   = r_retry;
    w_cmd_nxt     = r_cmd;
    w_got_fa_nxt  = r_got_fa;
    w_ack_got_nxt = r_ack_got;
    w_clk_oe_nxt  = r_clk_oe;
    w_data_oe_nxt = r_data_oe;
    w_retry_req   = 1'b0;

    case (r_state)
      S_INHIBIT: begin
        w_clk_oe_nxt  = 1'b1;
        w_data_oe_nxt = 1'b0;
        if (r_tmr >= 32'(INHIBIT_CYCLES - 1)) begin
          w_state_nxt   = S_RTS;
          w_data_oe_nxt = 1'b1;
          w_tmr_nxt     = '0;
          w_bit_cnt_nxt = '0;
        end
      end
      S_RTS: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b1;
        w_state_nxt   = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_fall) begin
          w_data_oe_nxt = ~w_bit;
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd9) begin
            w_state_nxt   = S_ACK;
            w_ack_got_nxt = 1'b0;
          end
        end else if (r_tmr >= 32'(TX_TIMEOUT - 1)) begin
          w_retry_req = 1'b1;
        end
      end
      S_ACK: begin
        if (!r_ack_got) begin
          if (w_fall) begin
            if (!r_dat_s2) w_ack_got_nxt = 1'b1;
            else           w_retry_req   = 1'b1;
          end else if (r_tmr >= 32'(TX_TIMEOUT - 1)) begin
            w_retry_req = 1'b1;
          end
        end else if (r_clk_s2) begin
          w_state_nxt = S_WAIT_RESP;
          w_tmr_nxt   = '0;
        end else if (r_tmr >= 32'(TX_TIMEOUT - 1)) begin
          w_retry_req = 1'b1;
        end
      end
      S_WAIT_RESP: begin
        if (bus.rx_valid) begin
          if (bus.rx_byte == 8'hFE) begin
            w_retry_req = 1'b1;
          end else if (r_cmd == 2'd0) begin
            if (bus.rx_byte == 8'hFC) begin
              w_state_nxt = S_FAIL;
            end else if (!r_got_fa && bus.rx_byte == 8'hFA) begin
              w_got_fa_nxt = 1'b1;
              w_retry_nxt  = '0;
              w_tmr_nxt    = '0;
            end else if (r_got_fa && bus.rx_byte == 8'hAA) begin
              w_retry_nxt = '0;
              w_tmr_nxt   = '0;
`ifdef PS2_TYPEMATIC_EN
              w_cmd_nxt    = 2'd1;
              w_got_fa_nxt = 1'b0;
              w_state_nxt  = S_INHIBIT;
`else
              w_state_nxt = S_READY;
`endif
            end
          end else if (bus.rx_byte == 8'hFA) begin
            w_retry_nxt = '0;
            w_tmr_nxt   = '0;
            if (r_cmd == 2'd1) begin
              w_cmd_nxt   = 2'd2;
              w_state_nxt = S_INHIBIT;
            end else begin
              w_state_nxt = S_READY;
            end
          end
        end else if (r_tmr >= 32'(RESP_TIMEOUT - 1)) begin
          w_retry_req = 1'b1;
        end
      end
      default: begin
        w_tmr_nxt     = r_tmr;
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
      end
    endcase

    // Retransmit the same byte from a fresh inhibit, or give up.
    if (w_retry_req) begin
      w_tmr_nxt     = '0;
      w_clk_oe_nxt  = 1'b0;
      w_data_oe_nxt = 1'b0;
      w_got_fa_nxt  = 1'b0;
      w_ack_got_nxt = 1'b0;
      if (r_retry >= RW'(MAX_RETRY)) begin
        w_state_nxt = S_FAIL;
      end else begin
        w_retry_nxt = r_retry + 1'b1;
        w_state_nxt = S_INHIBIT;
      end
    end
  end

  assign bus.ps2_clk_oe  = r_clk_oe;
  assign bus.ps2_data_oe = r_data_oe;
  assign bus.rx_enable   = (r_state == S_WAIT_RESP) || (r_state == S_READY);
  assign bus.ready       = (r_state == S_READY);
  assign bus.error       = (r_state == S_FAIL);

endmodule

`default_nettype wire
